// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: takes the PC, fetches over a valid/ready request and valid-only
// response memory port, and hands the word to decode with a valid/ready handshake.
module if_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013),
  parameter int unsigned     TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_err,
  output logic [31:0]     fetch_count
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]       state_q, state_n;
  logic             req_stall_q, req_stall_n;
  logic [XLEN-1:0]  addr_q, addr_n;
  logic             drop_q, drop_n;
  logic [CNT_W-1:0] tcnt_q, tcnt_n;
  logic             inst_valid_q, inst_valid_n;
  logic [XLEN-1:0]  inst_out_q, inst_out_n;
  logic [XLEN-1:0]  inst_pc_q, inst_pc_n;
  logic             err_q, err_n;
  logic [31:0]      count_q, count_n;

  logic             req_valid_c;
  logic [XLEN-1:0]  req_addr_c;
  logic             pc_en_c;
  logic             misalign_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_stall_q  <= 1'b0;
      addr_q       <= '0;
      drop_q       <= 1'b0;
      tcnt_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_INST;
      inst_pc_q    <= '0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_n;
      req_stall_q  <= req_stall_n;
      addr_q       <= addr_n;
      drop_q       <= drop_n;
      tcnt_q       <= tcnt_n;
      inst_valid_q <= inst_valid_n;
      inst_out_q   <= inst_out_n;
      inst_pc_q    <= inst_pc_n;
      err_q        <= err_n;
      count_q      <= count_n;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_n      = state_q;
    req_stall_n  = 1'b0;
    addr_n       = addr_q;
    drop_n       = drop_q;
    tcnt_n       = tcnt_q;
    inst_valid_n = inst_valid_q;
    inst_out_n   = inst_out_q;
    inst_pc_n    = inst_pc_q;
    err_n        = err_q;
    count_n      = count_q;
    req_valid_c  = 1'b0;
    req_addr_c   = addr_q;
    pc_en_c      = 1'b0;
    misalign_c   = (pc_in[1:0] != 2'b00);

    case (state_q)
      S_IDLE: begin
        state_n = S_REQ;
      end

      S_REQ: begin
        // A stalled request replays the latched address so it stays stable until accepted.
        if (req_stall_q) begin
          req_valid_c = 1'b1;
        end else if (misalign_c) begin
          err_n   = 1'b1;
          drop_n  = 1'b0;
          state_n = S_ERR;
        end else begin
          req_valid_c = 1'b1;
          req_addr_c  = pc_in;
        end
        if (req_valid_c) begin
          addr_n = req_addr_c;
          if (flush) begin
            drop_n = 1'b1;
          end
          if (imem_req_ready) begin
            tcnt_n  = '0;
            state_n = S_WAIT;
          end else begin
            req_stall_n = 1'b1;
          end
        end
      end

      S_WAIT: begin
        tcnt_n = tcnt_q + CNT_W'(1);
        if (imem_rsp_valid) begin
          if (drop_q || flush) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            inst_valid_n = 1'b1;
            inst_out_n   = imem_rsp_data;
            inst_pc_n    = addr_q;
            state_n      = S_HOLD;
          end
        end else if (tcnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          drop_n  = 1'b0;
          state_n = S_ERR;
        end else if (flush) begin
          drop_n = 1'b1;
        end
      end

      S_HOLD: begin
        // Flush takes priority over a same-cycle decode handshake.
        if (flush) begin
          inst_valid_n = 1'b0;
          inst_out_n   = NOP_INST;
          state_n      = S_REQ;
        end else if (inst_valid_q && inst_ready) begin
          pc_en_c      = 1'b1;
          count_n      = count_q + 32'd1;
          inst_valid_n = 1'b0;
          inst_out_n   = NOP_INST;
          state_n      = S_REQ;
        end
      end

      S_ERR: begin
        if (flush) begin
          err_n   = 1'b0;
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign pc_en          = pc_en_c & ~rst;
  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = req_addr_c;
  assign inst_valid     = inst_valid_q;
  assign inst_out       = inst_out_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = err_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table plus hand sequences for
// timeout and reset in the middle of a fetch.
module tb_if_fetch_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 16;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int unsigned NVEC = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch_unit #(.XLEN(XLEN), .NOP_INST(NOP), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_en          (pc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        rdy;
    logic        rspv;
    logic [31:0] data;
    logic        irdy;
    logic        pe;
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] io;
    logic [31:0] ip;
    logic        er;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic fl,
                              input logic rdy, input logic rspv, input logic [31:0] data,
                              input logic irdy, input logic pe, input logic rv,
                              input logic [31:0] ra, input logic iv, input logic [31:0] io,
                              input logic [31:0] ip, input logic er, input logic [31:0] fc);
    vec_t v;
    v.rst = r;   v.pc = pc;   v.flush = fl; v.rdy = rdy; v.rspv = rspv; v.data = data;
    v.irdy = irdy; v.pe = pe; v.rv = rv; v.ra = ra; v.iv = iv; v.io = io; v.ip = ip;
    v.er = er;   v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic pe, input logic rv,
                           input logic [31:0] ra, input logic iv, input logic [31:0] io,
                           input logic [31:0] ip, input logic er, input logic [31:0] fc);
    chk({tag, ".pc_en"},          32'(pc_en),          32'(pe));
    chk({tag, ".imem_req_valid"}, 32'(imem_req_valid), 32'(rv));
    chk({tag, ".imem_req_addr"},  imem_req_addr,       ra);
    chk({tag, ".inst_valid"},     32'(inst_valid),     32'(iv));
    chk({tag, ".inst_out"},       inst_out,            io);
    chk({tag, ".inst_pc"},        inst_pc,             ip);
    chk({tag, ".fetch_err"},      32'(fetch_err),      32'(er));
    chk({tag, ".fetch_count"},    fetch_count,         fc);
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [31:0] pc, input logic fl, input logic rdy,
                       input logic rspv, input logic [31:0] data, input logic irdy);
    @(negedge clk);
    rst = r; pc_in = pc; flush = fl; imem_req_ready = rdy;
    imem_rsp_valid = rspv; imem_rsp_data = data; inst_ready = irdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

    //            rst pc     fl rdy rspv data          irdy | pe rv ra     iv io            ip     er fc
    vecs[0]  = mk(1, 32'h0,  0, 0, 0, 32'h0,          0,    0, 0, 32'h0,  0, NOP,          32'h0,  0, 0);
    vecs[1]  = mk(0, 32'h0,  0, 0, 0, 32'h0,          0,    0, 0, 32'h0,  0, NOP,          32'h0,  0, 0);
    vecs[2]  = mk(0, 32'h0,  0, 1, 0, 32'h0,          0,    0, 1, 32'h0,  0, NOP,          32'h0,  0, 0);
    vecs[3]  = mk(0, 32'h0,  0, 1, 1, 32'h00500093,   0,    0, 0, 32'h0,  0, NOP,          32'h0,  0, 0);
    vecs[4]  = mk(0, 32'h0,  0, 0, 0, 32'h0,          1,    1, 0, 32'h0,  1, 32'h00500093, 32'h0,  0, 0);
    vecs[5]  = mk(0, 32'h4,  0, 1, 0, 32'h0,          0,    0, 1, 32'h4,  0, NOP,          32'h0,  0, 1);
    vecs[6]  = mk(0, 32'h4,  0, 0, 1, 32'h00a00113,   0,    0, 0, 32'h4,  0, NOP,          32'h0,  0, 1);
    vecs[7]  = mk(0, 32'h4,  0, 0, 0, 32'h0,          0,    0, 0, 32'h4,  1, 32'h00a00113, 32'h4,  0, 1);
    vecs[8]  = mk(0, 32'h4,  0, 0, 0, 32'h0,          0,    0, 0, 32'h4,  1, 32'h00a00113, 32'h4,  0, 1);
    vecs[9]  = mk(0, 32'h4,  0, 0, 1, 32'hFFFFFFFF,   0,    0, 0, 32'h4,  1, 32'h00a00113, 32'h4,  0, 1);
    vecs[10] = mk(0, 32'h4,  0, 0, 0, 32'h0,          0,    0, 0, 32'h4,  1, 32'h00a00113, 32'h4,  0, 1);
    vecs[11] = mk(0, 32'h4,  0, 0, 0, 32'h0,          0,    0, 0, 32'h4,  1, 32'h00a00113, 32'h4,  0, 1);
    vecs[12] = mk(0, 32'h4,  0, 0, 0, 32'h0,          1,    1, 0, 32'h4,  1, 32'h00a00113, 32'h4,  0, 1);
    vecs[13] = mk(0, 32'h8,  0, 0, 0, 32'h0,          0,    0, 1, 32'h8,  0, NOP,          32'h4,  0, 2);
    vecs[14] = mk(0, 32'h100,0, 0, 0, 32'h0,          0,    0, 1, 32'h8,  0, NOP,          32'h4,  0, 2);
    vecs[15] = mk(0, 32'h8,  0, 0, 0, 32'h0,          0,    0, 1, 32'h8,  0, NOP,          32'h4,  0, 2);
    vecs[16] = mk(0, 32'h8,  0, 1, 0, 32'h0,          0,    0, 1, 32'h8,  0, NOP,          32'h4,  0, 2);
    vecs[17] = mk(0, 32'h8,  1, 0, 0, 32'h0,          0,    0, 0, 32'h8,  0, NOP,          32'h4,  0, 2);
    vecs[18] = mk(0, 32'h8,  0, 0, 1, 32'hDEADBEEF,   0,    0, 0, 32'h8,  0, NOP,          32'h4,  0, 2);
    vecs[19] = mk(0, 32'h20, 0, 1, 0, 32'h0,          0,    0, 1, 32'h20, 0, NOP,          32'h4,  0, 2);
    vecs[20] = mk(0, 32'h20, 0, 0, 1, 32'h00c00193,   0,    0, 0, 32'h20, 0, NOP,          32'h4,  0, 2);
    vecs[21] = mk(0, 32'h20, 1, 0, 0, 32'h0,          1,    0, 0, 32'h20, 1, 32'h00c00193, 32'h20, 0, 2);
    vecs[22] = mk(0, 32'h6,  0, 1, 0, 32'h0,          0,    0, 0, 32'h20, 0, NOP,          32'h20, 0, 2);
    vecs[23] = mk(0, 32'h6,  0, 1, 0, 32'h0,          0,    0, 0, 32'h20, 0, NOP,          32'h20, 1, 2);
    vecs[24] = mk(0, 32'h6,  0, 1, 0, 32'h0,          0,    0, 0, 32'h20, 0, NOP,          32'h20, 1, 2);
    vecs[25] = mk(0, 32'h8,  1, 1, 0, 32'h0,          0,    0, 0, 32'h20, 0, NOP,          32'h20, 1, 2);
    vecs[26] = mk(0, 32'h8,  0, 1, 0, 32'h0,          0,    0, 1, 32'h8,  0, NOP,          32'h20, 0, 2);

    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].flush, vecs[i].rdy, vecs[i].rspv,
            vecs[i].data, vecs[i].irdy);
      check_all($sformatf("vec%0d", i), vecs[i].pe, vecs[i].rv, vecs[i].ra, vecs[i].iv,
                vecs[i].io, vecs[i].ip, vecs[i].er, vecs[i].fc);
    end

    // Silent memory: error must stay low for TMO waiting cycles, then rise.
    for (int k = 0; k < int'(TMO); k++) begin
      drive(0, 32'h8, 0, 1, 0, 32'h0, 0);
      check_all($sformatf("wait%0d", k), 0, 0, 32'h8, 0, NOP, 32'h20, 0, 2);
    end
    drive(0, 32'h8, 0, 1, 0, 32'h0, 0);
    check_all("timeout", 0, 0, 32'h8, 0, NOP, 32'h20, 1, 2);

    drive(0, 32'hC, 1, 1, 0, 32'h0, 0);
    check_all("tmo_flush", 0, 0, 32'h8, 0, NOP, 32'h20, 1, 2);
    drive(0, 32'hC, 0, 1, 0, 32'h0, 0);
    check_all("tmo_req", 0, 1, 32'hC, 0, NOP, 32'h20, 0, 2);

    // Reset while waiting, with a stale response arriving right after.
    drive(1, 32'hC, 0, 0, 0, 32'h0, 0);
    check_all("rst_wait", 0, 0, 32'hC, 0, NOP, 32'h20, 0, 2);
    drive(0, 32'h10, 0, 1, 1, 32'hBADC0DE5, 0);
    check_all("rst_idle", 0, 0, 32'h0, 0, NOP, 32'h0, 0, 0);
    drive(0, 32'h10, 0, 1, 0, 32'h0, 0);
    check_all("rst_req", 0, 1, 32'h10, 0, NOP, 32'h0, 0, 0);
    drive(0, 32'h10, 0, 0, 1, 32'h00100093, 0);
    check_all("rst_wait2", 0, 0, 32'h10, 0, NOP, 32'h0, 0, 0);
    drive(0, 32'h10, 0, 0, 0, 32'h0, 1);
    check_all("rst_hold", 1, 0, 32'h10, 1, 32'h00100093, 32'h10, 0, 0);
    drive(0, 32'h14, 0, 0, 0, 32'h0, 0);
    check_all("rst_next", 0, 1, 32'h14, 0, NOP, 32'h10, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
